// File: rtl/z3_cycle_sequencer.sv
// z3_cycle_sequencer -- Zorro III slave-cycle sequencer.
// Synchronises FCS_n/DS_n, decodes the address phase, steers the cycle to
// either the autoconfig block or the SDRAM controller and owns SLAVE_n/DTACK_n.
// Optional build macro: Z3_TIMEOUT_EN adds a Z3_DATA watchdog that forces
// termination after TIMEOUT_CYCLES clocks and raises a sticky bus_error.
module z3_cycle_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FCS_n,
    input  logic [3:0]  DS_n,
    input  logic        READ,
    input  logic [15:0] ADDR,
    input  logic        CFGIN_n,
    input  logic        configured,
    input  logic        shutup,
    input  logic [3:0]  ram_base_addr,
    input  logic        ac_dtack,
    input  logic        ram_ack,
    output logic [1:0]  z3_state,
    output logic        autoconfig_cycle,
    output logic        ram_cycle,
    output logic        ram_req,
    output logic        SLAVE_n,
    output logic        DTACK_n,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        Z3_IDLE  = 2'd0,
        Z3_START = 2'd1,
        Z3_DATA  = 2'd2,
        Z3_END   = 2'd3
    } z3_state_t;

    // Synchroniser chains: bit 0 is the first flop after the pin.
    logic [SYNC_STAGES-1:0]       fcs_sync_q;
    logic [SYNC_STAGES-1:0][3:0]  ds_sync_q;
    logic                         fcs_prev_q;

    z3_state_t state_q;
    logic      ac_match_q;
    logic      ram_match_q;

    logic fcs_s;
    logic ds_any_s;
    logic fcs_rise_s;
    logic ac_hit_s;
    logic ram_hit_s;
    logic ack_hit_s;
    logic unused_s;

    assign fcs_s      = ~fcs_sync_q[SYNC_STAGES-1];
    assign ds_any_s   = ~(&ds_sync_q[SYNC_STAGES-1]);
    assign fcs_rise_s = fcs_s & ~fcs_prev_q;

    // Address-phase decode; only autoconfig space at FF00 while unconfigured,
    // RAM space once the base has been assigned.
    assign ac_hit_s  = (ADDR == 16'hFF00) & ~CFGIN_n & ~configured & ~shutup;
    assign ram_hit_s = configured & (ADDR[15:12] == ram_base_addr);

    // Only the acknowledge of the target that owns the cycle counts.
    assign ack_hit_s = (autoconfig_cycle & ac_dtack) | (ram_cycle & ram_ack);

    assign z3_state = state_q;

`ifdef Z3_TIMEOUT_EN
    logic [7:0] timeout_cnt_q;
    // Bus direction does not influence sequencing.
    assign unused_s = READ;
`else
    // Bus direction does not influence sequencing; watchdog length unused here.
    assign unused_s  = ^{READ, 8'(TIMEOUT_CYCLES)};
    assign bus_error = 1'b0;
`endif

    // Strobe synchronisers and the delayed fcs copy used for edge detection.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fcs_sync_q <= {SYNC_STAGES{1'b1}};
            ds_sync_q  <= {SYNC_STAGES{4'hF}};
            fcs_prev_q <= 1'b0;
        end else begin
            fcs_sync_q <= {fcs_sync_q[SYNC_STAGES-2:0], FCS_n};
            ds_sync_q  <= {ds_sync_q[SYNC_STAGES-2:0], DS_n};
            fcs_prev_q <= fcs_s;
        end
    end

    // Cycle FSM with all bus-facing outputs registered.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q          <= Z3_IDLE;
            ac_match_q       <= 1'b0;
            ram_match_q      <= 1'b0;
            autoconfig_cycle <= 1'b0;
            ram_cycle        <= 1'b0;
            ram_req          <= 1'b0;
            SLAVE_n          <= 1'b1;
            DTACK_n          <= 1'b1;
`ifdef Z3_TIMEOUT_EN
            timeout_cnt_q    <= 8'd0;
            bus_error        <= 1'b0;
`endif
        end else begin
            // ram_req is a single-clock pulse unless re-armed below.
            ram_req <= 1'b0;
            case (state_q)
                Z3_IDLE: begin
                    // A non-matching address leaves us idle until the next fcs edge.
                    if (fcs_rise_s && (ac_hit_s || ram_hit_s)) begin
                        state_q     <= Z3_START;
                        ac_match_q  <= ac_hit_s;
                        ram_match_q <= ~ac_hit_s & ram_hit_s;
                    end else begin
                        state_q <= Z3_IDLE;
                    end
                end
                Z3_START: begin
                    SLAVE_n          <= 1'b0;
                    autoconfig_cycle <= ac_match_q;
                    ram_cycle        <= ram_match_q;
                    if (!fcs_s) begin
                        // Strobe withdrawn before any data strobe: no data phase.
                        state_q <= Z3_END;
                    end else if (ds_any_s) begin
                        state_q <= Z3_DATA;
                        ram_req <= ram_match_q;
`ifdef Z3_TIMEOUT_EN
                        timeout_cnt_q <= 8'd0;
`endif
                    end else begin
                        state_q <= Z3_START;
                    end
                end
                Z3_DATA: begin
                    if (ack_hit_s) begin
                        DTACK_n <= 1'b0;
                        state_q <= Z3_END;
                    end else if (!fcs_s) begin
                        // Bus abort: finish without acknowledging.
                        state_q <= Z3_END;
`ifdef Z3_TIMEOUT_EN
                    end else if (timeout_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                        DTACK_n   <= 1'b0;
                        bus_error <= 1'b1;
                        state_q   <= Z3_END;
                    end else begin
                        timeout_cnt_q <= timeout_cnt_q + 8'd1;
                        state_q       <= Z3_DATA;
`else
                    end else begin
                        state_q <= Z3_DATA;
`endif
                    end
                end
                Z3_END: begin
                    // Hold the response until the master drops the strobe.
                    if (!fcs_s) begin
                        SLAVE_n          <= 1'b1;
                        DTACK_n          <= 1'b1;
                        autoconfig_cycle <= 1'b0;
                        ram_cycle        <= 1'b0;
                        state_q          <= Z3_IDLE;
                    end else begin
                        state_q <= Z3_END;
                    end
                end
                default: begin
                    state_q <= Z3_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/z3_cycle_sequencer.md
Name: z3_cycle_sequencer

Overview:
- Zorro III slave-cycle sequencer between the raw bus signals and the board's internal resources.
- Synchronises the bus strobes, latches and decodes the address phase, and drives the shared z3_state[1:0].
- Steers each cycle to exactly one target: the autoconfig block or the SDRAM controller.
- Merges the selected target's acknowledge into SLAVE_n/DTACK_n and owns cycle termination.

Parameters:
SYNC_STAGES, 2, flip-flop stages on FCS_n and DS_n[3:0] (legal 2-3).
TIMEOUT_CYCLES, 255, CLK cycles in Z3_DATA before abort (used only with Z3_TIMEOUT_EN); 8-bit counter.

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous reset, active-high
FCS_n  in  1  Zorro III full cycle strobe (async)
DS_n  in  4  data strobes (async)
READ  in  1  bus read/write
ADDR  in  16  latched bus address [31:16]
CFGIN_n  in  1  autoconfig chain enable
configured  in  1  RAM base assigned
shutup  in  1  board told to shut up
ram_base_addr  in  4  RAM base, compared with ADDR[31:28]
ac_dtack  in  1  autoconfig data acknowledge
ram_ack  in  1  SDRAM controller data done
z3_state  out  2  Z3_IDLE=0, Z3_START=1, Z3_DATA=2, Z3_END=3
autoconfig_cycle  out  1  current cycle targets autoconfig
ram_cycle  out  1  current cycle targets RAM
ram_req  out  1  one-cycle RAM request pulse
SLAVE_n  out  1  slave response
DTACK_n  out  1  data acknowledge
bus_error  out  1  sticky timeout flag (Z3_TIMEOUT_EN only, else 0)

Behaviour:
- Reset, synchronous on CLK while RESET=1: z3_state=Z3_IDLE, autoconfig_cycle=0, ram_cycle=0, ram_req=0, SLAVE_n=1, DTACK_n=1, bus_error=0, synchroniser flops=1.
- fcs = !FCS_n after SYNC_STAGES flops; ds_any = any bit of synchronised DS_n low.
- Z3_IDLE → Z3_START on fcs rising edge. In the same cycle, ADDR is sampled into an internal register and decoded:
  - autoconfig match: ADDR==16'hFF00 && !CFGIN_n && !configured && !shutup.
  - RAM match: configured && ADDR[15:12]==ram_base_addr.
  - Autoconfig has priority; both matches can only coincide on bad config.
  - No match: remain in Z3_IDLE, no outputs asserted until fcs falls and rises again.
- Z3_START: assert SLAVE_n=0 and the matching *_cycle flag. Move to Z3_DATA on the first cycle ds_any=1.
  - fcs drops before ds_any: go straight to Z3_END, with no ram_req and no DTACK.
- Z3_DATA:
  - On entry, ram_req pulses high for exactly 1 CLK, only if ram_cycle.
  - Terminate on (autoconfig_cycle && ac_dtack) or (ram_cycle && ram_ack). Termination drives DTACK_n=0 on the next CLK edge and moves to Z3_END.
  - ac_dtack or ram_ack arriving for the non-selected target is ignored.
- Z3_END:
  - Hold DTACK_n=0 and SLAVE_n=0 until fcs=0.
  - Then release SLAVE_n=1, DTACK_n=1, clear both *_cycle flags, return to Z3_IDLE.
  - Minimum 1 CLK in Z3_END.
- fcs deasserting in Z3_DATA before the ack (bus abort): go to Z3_END, release outputs the following cycle. A later ram_ack is ignored.
- New fcs rising while not in Z3_IDLE: ignored. A cycle must pass through Z3_IDLE first.
- RESET mid-cycle: all outputs return to reset values on the next edge, regardless of state.
- Outputs are registered; no combinational path from bus pins to outputs.
- Latency, autoconfig: fcs edge at pin to SLAVE_n low is SYNC_STAGES+2 CLKs.

Optional Feature:
Z3_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on Z3_DATA entry and increments each CLK in Z3_DATA.
  - When it reaches TIMEOUT_CYCLES with no ack, force DTACK_n=0, go to Z3_END, set bus_error=1.
  - bus_error stays set until RESET.
- Undefined: no counter, bus_error tied 0, Z3_DATA waits indefinitely.

Test Plan:
- Autoconfig read: CFGIN_n=0, configured=0, ADDR=FF00, FCS_n low, DS_n=0 → autoconfig_cycle=1 and SLAVE_n=0 at SYNC_STAGES+2. ac_dtack at cycle k → DTACK_n=0 at k+1. FCS_n high → Z3_IDLE, outputs released.
- RAM write: configured=1, ram_base_addr=4, ADDR=4123 → ram_cycle=1, single ram_req pulse. ram_ack after 5 CLKs → DTACK_n low the next cycle, then Z3_END.
- No match: configured=1, ram_base_addr=4, ADDR=5000 → z3_state stays 0, SLAVE_n stays 1 for the whole strobe.
- Abort: RAM cycle in Z3_DATA, FCS_n high before ram_ack → Z3_END then Z3_IDLE; a late ram_ack produces no DTACK_n.
- Reset mid-cycle: RESET=1 in Z3_DATA → next edge z3_state=0, SLAVE_n=1, DTACK_n=1, ram_cycle=0.
- Z3_TIMEOUT_EN, TIMEOUT_CYCLES=16: RAM cycle, ram_ack held 0 → DTACK_n low after 16 DATA cycles, bus_error=1 sticky until RESET.
